// File: rtl/sevseg_scan_decoder.sv
// Passive monitor for a multiplexed 4-digit active-low seven-segment bus: waits for each
// digit to dwell stably, decodes it to hex, and reports completed frames and bus errors.
module sevseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] segEn,
  input  logic [6:0] seg,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic [3:0] valid,
  output logic       frame_done,
  output logic       err
);

  localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);

  logic [3:0]  smpEn, prevEn;
  logic [6:0]  smpSeg, prevSeg;
  logic [15:0] dwellCnt, cntNext;
  logic [3:0]  seen, seenNext;
  logic        sampleChanged, isActive, isIllegal, decodeFire, segHit;
  logic [1:0]  pos;
  logic [3:0]  segVal;

  // prevEn/prevSeg hold the sample before smpEn/smpSeg, so the dwell is judged on registered data.
  assign sampleChanged = (smpEn != prevEn) || (smpSeg != prevSeg);
  assign cntNext = sampleChanged ? 16'd1 :
                   (dwellCnt == 16'hFFFF) ? dwellCnt : dwellCnt + 16'd1;
  // The extra term stops a re-decode once the counter saturates at STABLE.
  assign decodeFire = isActive && (cntNext == STABLE) && (sampleChanged || dwellCnt != STABLE);
  assign seenNext = seen | (4'b0001 << pos);

  always_comb begin
    isActive  = 1'b0;
    isIllegal = 1'b0;
    pos       = 2'd0;
    case (smpEn)
      4'b1110: begin isActive = 1'b1; pos = 2'd0; end
      4'b1101: begin isActive = 1'b1; pos = 2'd1; end
      4'b1011: begin isActive = 1'b1; pos = 2'd2; end
      4'b0111: begin isActive = 1'b1; pos = 2'd3; end
      4'b1111: begin end
      default: isIllegal = 1'b1;
    endcase
  end

  always_comb begin
    segHit = 1'b1;
    segVal = 4'h0;
    case (smpSeg)
      7'b1000000: segVal = 4'h0;
      7'b1111001: segVal = 4'h1;
      7'b0100100: segVal = 4'h2;
      7'b0110000: segVal = 4'h3;
      7'b0011001: segVal = 4'h4;
      7'b0010010: segVal = 4'h5;
      7'b0000010: segVal = 4'h6;
      7'b1111000: segVal = 4'h7;
      7'b0000000: segVal = 4'h8;
      7'b0010000: segVal = 4'h9;
      7'b0001000: segVal = 4'hA;
      7'b0000011: segVal = 4'hB;
      7'b1000110: segVal = 4'hC;
      7'b0100001: segVal = 4'hD;
      7'b0000110: segVal = 4'hE;
      7'b0001110: segVal = 4'hF;
      default:    segHit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smpEn      <= 4'b1111;
      smpSeg     <= 7'b1111111;
      prevEn     <= 4'b1111;
      prevSeg    <= 7'b1111111;
      dwellCnt   <= 16'd1;
      seen       <= 4'b0000;
      valid      <= 4'b0000;
      disp0      <= 4'h0;
      disp1      <= 4'h0;
      disp2      <= 4'h0;
      disp3      <= 4'h0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      smpEn      <= segEn;
      smpSeg     <= seg;
      prevEn     <= smpEn;
      prevSeg    <= smpSeg;
      dwellCnt   <= cntNext;
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (isIllegal && sampleChanged) err <= 1'b1;
      if (decodeFire) begin
        if (segHit) begin
          case (pos)
            2'd0: disp0 <= segVal;
            2'd1: disp1 <= segVal;
            2'd2: disp2 <= segVal;
            default: disp3 <= segVal;
          endcase
          valid[pos] <= 1'b1;
          if (seenNext == 4'b1111) begin
            frame_done <= 1'b1;
            seen       <= 4'b0000;
          end else begin
            seen <= seenNext;
          end
        end else begin
          err        <= 1'b1;
          valid[pos] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// Bench for sevseg_scan_decoder: a scenario table plus randomized traffic, both checked every
// cycle against a history-based model of the dwell/decode rules (one DUT at 16, one at 1).
module tb_sevseg_scan_decoder;

  localparam logic [10:0] IDLE_SMP = 11'h7FF;
  localparam logic [6:0] DIGIT_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clk = 1'b0;
  logic rst;
  logic [3:0] enA, enB;
  logic [6:0] segA, segB;
  logic [3:0] aD3, aD2, aD1, aD0, aValid, bD3, bD2, bD1, bD0, bValid;
  logic aFrame, aErr, bFrame, bErr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sevseg_scan_decoder #(.STABLE_CYCLES(16)) dutA (
    .clk(clk), .rst(rst), .segEn(enA), .seg(segA),
    .disp3(aD3), .disp2(aD2), .disp1(aD1), .disp0(aD0),
    .valid(aValid), .frame_done(aFrame), .err(aErr));

  sevseg_scan_decoder #(.STABLE_CYCLES(1)) dutB (
    .clk(clk), .rst(rst), .segEn(enB), .seg(segB),
    .disp3(bD3), .disp2(bD2), .disp1(bD1), .disp0(bD0),
    .valid(bValid), .frame_done(bFrame), .err(bErr));

  // Reference model: port values seen before each edge since reset, plus expected outputs.
  logic [10:0] histA[$];
  logic [10:0] histB[$];
  logic [3:0]  mDisp [2][4];
  logic [3:0]  mValid [2];
  logic [3:0]  mSeen [2];
  logic        mErr [2];
  logic        mFrame [2];
  int          stableOf [2] = '{16, 1};

  function automatic logic [10:0] histAt(input int id, input int j);
    if (j < 1) return IDLE_SMP;
    return (id == 0) ? histA[j-1] : histB[j-1];
  endfunction

  task automatic modelReset();
    histA.delete();
    histB.delete();
    for (int id = 0; id < 2; id++) begin
      for (int p = 0; p < 4; p++) mDisp[id][p] = 4'h0;
      mValid[id] = 4'h0;
      mSeen[id]  = 4'h0;
      mErr[id]   = 1'b0;
      mFrame[id] = 1'b0;
    end
  endtask

  // A digit is accepted when it was present for exactly the last S edges before the previous one.
  task automatic modelEdge(input int id);
    int k, zeros, pos, val, s;
    logic [10:0] cur;
    bit run;
    k = (id == 0) ? histA.size() : histB.size();
    s = stableOf[id];
    cur = histAt(id, k - 1);
    mErr[id] = 1'b0;
    mFrame[id] = 1'b0;
    zeros = 4 - $countones(cur[10:7]);
    if (zeros >= 2) begin
      if (histAt(id, k - 2) != cur) mErr[id] = 1'b1;
    end else if (zeros == 1) begin
      run = (histAt(id, k - 1 - s) != cur);
      for (int m = 0; m < s; m++) if (histAt(id, k - 1 - m) != cur) run = 1'b0;
      if (run) begin
        pos = 0;
        for (int i = 0; i < 4; i++) if (!cur[7+i]) pos = i;
        val = -1;
        for (int d = 0; d < 16; d++) if (DIGIT_SEG[d] == cur[6:0]) val = d;
        if (val < 0) begin
          mErr[id] = 1'b1;
          mValid[id][pos] = 1'b0;
        end else begin
          mDisp[id][pos] = val[3:0];
          mValid[id][pos] = 1'b1;
          mSeen[id][pos] = 1'b1;
          if (mSeen[id] == 4'hF) begin
            mFrame[id] = 1'b1;
            mSeen[id] = 4'h0;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkDut(input int id);
    logic [21:0] act, exp;
    exp = {mDisp[id][3], mDisp[id][2], mDisp[id][1], mDisp[id][0], mValid[id], mFrame[id], mErr[id]};
    if (id == 0) act = {aD3, aD2, aD1, aD0, aValid, aFrame, aErr};
    else         act = {bD3, bD2, bD1, bD0, bValid, bFrame, bErr};
    check((id == 0) ? "model_s16" : "model_s1", 32'(act), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    histA.push_back({enA, segA});
    histB.push_back({enB, segB});
    modelEdge(0);
    modelEdge(1);
    @(negedge clk);
    checkDut(0);
    checkDut(1);
  endtask

  // Outputs must clear immediately, without waiting for a clock edge.
  task automatic doReset();
    rst = 1'b0;
    #1;
    modelReset();
    checkDut(0);
    checkDut(1);
    @(negedge clk);
    checkDut(0);
    checkDut(1);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [6:0]  seg;
    int          hold;
    logic [15:0] disp;
    logic [3:0]  valid;
    int          errs;
    int          frames;
    int          firstChange;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [19:0] startState, nowState;
    int errs, frames, first, at;
    logic [3:0] lastDigit [4];
    logic [3:0] ren;
    logic [6:0] rseg;
    int r, hold;

    vecs[0]  = '{4'b1110, 7'b0110000, 20, 16'h0003, 4'b0001, 0, 0, 17};
    vecs[1]  = '{4'b1110, 7'b1111001, 20, 16'h0001, 4'b0001, 0, 0, 17};
    vecs[2]  = '{4'b1101, 7'b0100100, 20, 16'h0021, 4'b0011, 0, 0, 17};
    vecs[3]  = '{4'b1011, 7'b0001000, 20, 16'h0A21, 4'b0111, 0, 0, 17};
    vecs[4]  = '{4'b0111, 7'b0001110, 20, 16'hFA21, 4'b1111, 0, 1, 17};
    vecs[5]  = '{4'b1110, 7'b0010010, 15, 16'hFA21, 4'b1111, 0, 0, 0};
    vecs[6]  = '{4'b1101, 7'b1111000, 20, 16'hFA71, 4'b1111, 0, 0, 17};
    vecs[7]  = '{4'b1100, 7'b0000000, 30, 16'hFA71, 4'b1111, 1, 0, 0};
    vecs[8]  = '{4'b1011, 7'b1111111, 20, 16'hFA71, 4'b1011, 1, 0, 17};
    vecs[9]  = '{4'b1111, 7'b1111111, 20, 16'hFA71, 4'b1011, 0, 0, 0};
    vecs[10] = '{4'b1111, 7'b0000000, 10, 16'hFA71, 4'b1011, 0, 0, 0};

    enA = 4'b1111; segA = 7'b1111111;
    enB = 4'b1111; segB = 7'b1111111;
    doReset();

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      enA = v.en;
      segA = v.seg;
      startState = {aD3, aD2, aD1, aD0, aValid};
      errs = 0; frames = 0; first = 0;
      for (int c = 1; c <= v.hold; c++) begin
        tick();
        if (aErr) errs++;
        if (aFrame) begin
          frames++;
          check("frame_with_disp3", 32'(aD3), 32'(v.disp[15:12]));
        end
        nowState = {aD3, aD2, aD1, aD0, aValid};
        if (first == 0 && nowState != startState) first = c;
      end
      check($sformatf("vec%0d_disp", i), 32'({aD3, aD2, aD1, aD0}), 32'(v.disp));
      check($sformatf("vec%0d_valid", i), 32'(aValid), 32'(v.valid));
      check($sformatf("vec%0d_errs", i), 32'(errs), 32'(v.errs));
      check($sformatf("vec%0d_frames", i), 32'(frames), 32'(v.frames));
      check($sformatf("vec%0d_update_edge", i), 32'(first), 32'(v.firstChange));
    end

    // Reset ten cycles into a dwell, then require a full dwell after release.
    enA = 4'b1110; segA = 7'b0000000;
    repeat (10) tick();
    doReset();
    at = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (at == 0 && aValid[0]) at = c;
    end
    check("rst_redwell_edge", 32'(at), 32'd17);
    check("rst_redwell_disp0", 32'(aD0), 32'h8);

    // One-cycle dwell: a new position every cycle.
    enA = 4'b1111; segA = 7'b1111111;
    frames = 0;
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int p = 0; p < 4; p++) begin
        r = $urandom_range(0, 15);
        lastDigit[p] = r[3:0];
        enB = ~(4'b0001 << p);
        segB = DIGIT_SEG[r];
        tick();
        if (bFrame) frames++;
      end
    end
    enB = 4'b1111; segB = 7'b1111111;
    repeat (3) begin
      tick();
      if (bFrame) frames++;
    end
    check("s1_frames", 32'(frames), 32'd3);
    check("s1_valid", 32'(bValid), 32'hF);
    check("s1_disp", 32'({bD3, bD2, bD1, bD0}),
          32'({lastDigit[3], lastDigit[2], lastDigit[1], lastDigit[0]}));

    // Randomized traffic on both instances, checked every cycle by the model.
    for (int it = 0; it < 70; it++) begin
      if (it == 35) doReset();
      r = $urandom_range(0, 99);
      if (r < 70) begin
        ren = ~(4'b0001 << $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) rseg = 7'($urandom_range(0, 127));
        else rseg = DIGIT_SEG[$urandom_range(0, 15)];
      end else if (r < 85) begin
        ren = 4'b1111;
        rseg = 7'($urandom_range(0, 127));
      end else begin
        ren = 4'($urandom_range(0, 15));
        while ($countones(ren) >= 3) ren = 4'($urandom_range(0, 15));
        rseg = 7'($urandom_range(0, 127));
      end
      enA = ren; segA = rseg;
      enB = ren; segB = rseg;
      hold = $urandom_range(1, 24);
      repeat (hold) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevseg_scan_decoder.md
SEVSEG_SCAN_DECODER -- requirements
Module: sevseg_scan_decoder

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 16, meaning the consecutive identical-sample count needed to accept a digit (legal range 1..65535).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port segEn, input, 4, the monitored digit enables: active-low, bit i selects position i.
REQ-005 The block SHALL have port seg, input, 7, the monitored segment lines: active-low, bit order {g,f,e,d,c,b,a}.
REQ-006 The block SHALL have ports disp3, disp2, disp1, disp0, output, 4 each, the last accepted hex value per position.
REQ-007 The block SHALL have port valid, output, 4, where bit i=1 means disp<i> holds a decoded value.
REQ-008 The block SHALL have port frame_done, output, 1, a one-cycle pulse when all four positions have been accepted since the previous pulse.
REQ-009 The block SHALL have port err, output, 1, a one-cycle pulse on an illegal enable pattern or an undecodable segment pattern.

Function
REQ-010 The block SHALL register segEn and seg once (sample stage) and SHALL apply all checks to the registered values only.
REQ-011 The block SHALL treat a sample as "active" when exactly one segEn bit is 0, "idle" when all are 1, and "illegal" otherwise.
REQ-012 A dwell counter (16 bits, saturating) SHALL reset to 1 whenever the sample differs from the previous sample in segEn or seg, and SHALL increment otherwise.
REQ-013 When an active sample's counter reaches STABLE_CYCLES, the block SHALL decode it exactly once for that dwell, with no re-decode until the sample changes.
REQ-014 Decode table (seg, active-low, in hex digit order 0-F) SHALL be: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-015 On a matching decode, the block SHALL load the value into disp<i>, set valid[i], and set seen[i] in the internal 4-bit seen mask.
REQ-016 On a non-matching decode, the block SHALL pulse err, clear valid[i], leave disp<i> unchanged, and leave seen[i] unchanged.
REQ-017 Decode latency: outputs SHALL update on the (STABLE_CYCLES+1)th rising edge after the pattern first appears at the ports.
REQ-018 An illegal sample SHALL pulse err once on the first cycle it is registered, with no further pulses while it persists unchanged, and SHALL NOT update disp, valid or seen.
REQ-019 An idle sample SHALL never decode, never flag err, and SHALL leave all outputs except the pulses unchanged.
REQ-020 When the seen mask becomes 1111, the block SHALL pulse frame_done in the same cycle that the final disp update becomes visible, and SHALL clear seen in that same edge.
REQ-021 If the same position is accepted twice before a frame completes, disp SHALL take the newer value and seen SHALL be unaffected.
REQ-022 err and frame_done SHALL be able to pulse in the same cycle only if produced by different causes; err SHALL take no priority over the decode update.
REQ-023 With STABLE_CYCLES=1, every changed active sample SHALL decode on the edge after it is registered.

Reset
REQ-024 While rst=0, the block SHALL asynchronously clear disp0..disp3 to 0, valid to 0000, seen to 0000, frame_done to 0, err to 0, and the counter and sample register to their idle state (segEn=1111, seg=1111111).
REQ-025 On rst release, the first decode SHALL require a full STABLE_CYCLES dwell measured from release.
REQ-026 An rst assertion mid-dwell SHALL abort the pending decode with no err and no frame_done.

Verification
REQ-027 Scenario 1: STABLE_CYCLES=16; drive segEn=1110, seg=0110000 for 20 cycles -> on edge 17, disp0=3 and valid=0001, no err.
REQ-028 Scenario 2: cycle positions 0..3 with seg for 1,2,A,F, 20 cycles each -> one frame_done pulse coincident with disp3=F; valid=1111; disp=F,A,2,1.
REQ-029 Scenario 3: hold segEn=1110 for only 15 cycles, then 1101 -> no disp0 update and no err.
REQ-030 Scenario 4: drive segEn=1100 for 30 cycles -> exactly one err pulse, all outputs otherwise unchanged; then drive seg=1111111 on segEn=1011 for 20 cycles -> one err pulse, valid[2]=0.
REQ-031 Scenario 5: assert rst at cycle 10 of a 16-cycle dwell -> all outputs zero immediately, no pulse; after release, decode occurs only after a full 16-cycle dwell.
REQ-032 Scenario 6: STABLE_CYCLES=1 with the digit changing every cycle across positions 0..3 -> each digit decodes, frame_done pulses once per four positions.
